exec_cmd: RTL and testbench
===========================

// Module: exec_cmd
// PURPOSE
//  Command-list executor of the UDP control path. On start, reads a 16-bit command list from the input RAM,
//  performs 32-bit register reads/writes on the register bus, and writes read results to the output RAM.
//  Sits between the UDP controller (which fills the input RAM and sends the output RAM) and the register bus.
// PARAMETERS
//  AW       10    RAM address width (input and output RAM depth = 2**AW 16-bit words)
//  TIMEOUT  1023  max cycles to wait for reg_ready before aborting with err
// PORTS
//  clk            in   1    single clock, all logic on rising edge
//  rst            in   1    asynchronous, active-low reset
//  start_exec     in   1    start pulse; ignored while busy
//  busy           out  1    high from cycle after accepted start until completion/abort
//  err            out  1    abort flag of last run; valid when busy low
//  out_len        out  AW   index of last output word written; valid when busy low
//  inram_address  out  AW   input RAM word address
//  inram_re       out  1    input RAM read enable; q valid one cycle after address+re
//  inram_q        in   16   input RAM read data
//  outram_address out  AW   output RAM word address
//  outram_we      out  1    output RAM write enable
//  outram_d       out  16   output RAM write data
//  reg_addr       out  14   register address
//  reg_rd         out  1    register read request
//  reg_wr         out  1    register write request
//  reg_writedata  out  32   register write data
//  reg_ready      in   1    request complete (readdata valid same cycle for reads)
//  reg_readdata   in   32   register read data
// BEHAVIOUR
//  Reset: busy=0, err=0, out_len=0, reg_rd=reg_wr=0, inram_re=0, outram_we=0; all addresses/data 0.
//  Input list: word0 = L (index of last word); words 1..L-1 = commands; word L must be 16'hCBAE.
//  Command: opcode word bit15 = 1 write / 0 read, bit14 reserved (ignored), bits13:0 = reg_addr.
//   Write: followed by data_hi, data_lo words; reg_writedata = {hi,lo}. Read: opcode word only.
//  Output list: word0 = 16'hCBAE; each read appends readdata[31:16] then readdata[15:0].
//   out_len = index of last word written (0 when no reads).
//  FSM: IDLE -> RD_LEN -> CHK_MAGIC -> FETCH_OP -> [FETCH_HI -> FETCH_LO] -> BUS -> [STORE_HI -> STORE_LO]
//   -> FETCH_OP ... -> DONE -> IDLE. Each RAM fetch is address+re cycle plus one data cycle.
//  Start accepted only in IDLE; busy rises next cycle; err and out_len cleared on accept.
//  RD_LEN: L==0, L==1 or L > 2**AW-1 -> abort. CHK_MAGIC: word L != 16'hCBAE -> abort before any bus access.
//  outram word0 (16'hCBAE) written once the magic check passes, before the first command is fetched.
//  Command pointer reaches L -> DONE (normal end). Write whose data words would reach index L -> abort (truncated).
//  BUS: reg_rd or reg_wr held high with stable reg_addr/writedata until reg_ready sampled high;
//   deasserted the following cycle; readdata captured on the reg_ready cycle. Never rd and wr together.
//  reg_ready not seen within TIMEOUT cycles -> drop request, abort.
//  Output overflow (a read needing index > 2**AW-1) -> abort without writing.
//  Abort: err=1, busy falls next cycle, out_len = last index written so far; commands already done stay done.
//  busy falls one cycle after DONE/abort; out_len/err stable until next accepted start.
//  start_exec while busy ignored; async reset mid-run returns to IDLE immediately, pending request dropped.
//  RAM addresses only driven meaningfully while busy (caller muxes RAM ownership on busy).
// TESTING
//  L=3, {0x8010,0x1234,0x5678} no magic at 4? -> use list {3,0x0010,0xCBAE... }: see below cases.
//  List {4,0x8010,0x1234,0x5678,0xCBAE} -> one reg_wr addr 0x010 data 0x12345678; err=0, out_len=0.
//  List {2,0x0005,0xCBAE}, readdata 0xDEADBEEF, reg_ready after 3 cycles -> outram {CBAE,DEAD,BEEF}, out_len=2.
//  List {2,0x0005,0x1111} -> err=1, no reg_rd/reg_wr ever asserted, busy high <=6 cycles.
//  List {3,0x8001,0x0000,0xCBAE} (truncated write) -> err=1, no reg_wr.
//  Read with reg_ready held low -> err=1 after TIMEOUT cycles; reg_rd deasserted; second start in busy ignored.
//  Assert rst low mid-BUS -> busy=0, reg_rd=0 immediately; next start runs cleanly.

Source files
------------

// File: rtl/exec_cmd.sv
// ----------------------------------------------------------------------------
// exec_cmd
//   Command-list executor for the UDP control path. On a start pulse it walks
//   a 16-bit command list held in the input RAM, issues 32-bit register reads
//   and writes on the register bus, and appends read results to the output
//   RAM. The output list begins with the 16'hCBAE marker word.
//
// Ports
//   clk, rst            single rising-edge clock, asynchronous active-low reset
//   start_exec          start pulse, only accepted while idle
//   busy, err, out_len  run status; err/out_len valid while busy is low
//   inram_*             input RAM read port (q valid one cycle after re)
//   outram_*            output RAM write port
//   reg_*               register bus request/handshake
// ----------------------------------------------------------------------------
module exec_cmd #(
    parameter int unsigned AW      = 10,
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_exec,
    output logic          busy,
    output logic          err,
    output logic [AW-1:0] out_len,
    output logic [AW-1:0] inram_address,
    output logic          inram_re,
    input  logic [15:0]   inram_q,
    output logic [AW-1:0] outram_address,
    output logic          outram_we,
    output logic [15:0]   outram_d,
    output logic [13:0]   reg_addr,
    output logic          reg_rd,
    output logic          reg_wr,
    output logic [31:0]   reg_writedata,
    input  logic          reg_ready,
    input  logic [31:0]   reg_readdata
);

    localparam int unsigned MAXI  = (1 << AW) - 1;
    localparam int unsigned TW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [15:0] MAGIC = 16'hCBAE;

    typedef enum logic [3:0] {
        S_IDLE,
        S_RD_LEN,
        S_CHK_MAGIC,
        S_FETCH_OP,
        S_FETCH_HI,
        S_FETCH_LO,
        S_BUS,
        S_STORE_HI,
        S_STORE_LO,
        S_DONE
    } state_t;

    state_t        r_state, w_state;
    logic          r_ph, w_ph;          // fetch phase: 0 = address+re, 1 = data
    logic          r_busy, w_busy;
    logic          r_err, w_err;
    logic [AW-1:0] r_out_len, w_out_len;
    logic [AW-1:0] r_in_addr, w_in_addr;
    logic          r_in_re, w_in_re;
    logic [AW-1:0] r_out_addr, w_out_addr;
    logic          r_out_we, w_out_we;
    logic [15:0]   r_out_d, w_out_d;
    logic [13:0]   r_reg_addr, w_reg_addr;
    logic          r_reg_rd, w_reg_rd;
    logic          r_reg_wr, w_reg_wr;
    logic [31:0]   r_wdata, w_wdata;
    logic [15:0]   r_rd_lo, w_rd_lo;
    logic [AW-1:0] r_len, w_len;
    logic [AW-1:0] r_ptr, w_ptr;        // index of the next list word to consume
    logic [TW-1:0] r_tmo, w_tmo;
    logic          w_abort;
    logic          w_next_op;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_ph       <= 1'b0;
            r_busy     <= 1'b0;
            r_err      <= 1'b0;
            r_out_len  <= '0;
            r_in_addr  <= '0;
            r_in_re    <= 1'b0;
            r_out_addr <= '0;
            r_out_we   <= 1'b0;
            r_out_d    <= '0;
            r_reg_addr <= '0;
            r_reg_rd   <= 1'b0;
            r_reg_wr   <= 1'b0;
            r_wdata    <= '0;
            r_rd_lo    <= '0;
            r_len      <= '0;
            r_ptr      <= '0;
            r_tmo      <= '0;
        end else begin
            r_state    <= w_state;
            r_ph       <= w_ph;
            r_busy     <= w_busy;
            r_err      <= w_err;
            r_out_len  <= w_out_len;
            r_in_addr  <= w_in_addr;
            r_in_re    <= w_in_re;
            r_out_addr <= w_out_addr;
            r_out_we   <= w_out_we;
            r_out_d    <= w_out_d;
            r_reg_addr <= w_reg_addr;
            r_reg_rd   <= w_reg_rd;
            r_reg_wr   <= w_reg_wr;
            r_wdata    <= w_wdata;
            r_rd_lo    <= w_rd_lo;
            r_len      <= w_len;
            r_ptr      <= w_ptr;
            r_tmo      <= w_tmo;
        end
    end

    always_comb begin
        w_state    = r_state;
        w_ph       = r_ph;
        w_busy     = r_busy;
        w_err      = r_err;
        w_out_len  = r_out_len;
        w_in_addr  = r_in_addr;
        w_in_re    = 1'b0;
        w_out_addr = r_out_addr;
        w_out_we   = 1'b0;
        w_out_d    = r_out_d;
        w_reg_addr = r_reg_addr;
        w_reg_rd   = r_reg_rd;
        w_reg_wr   = r_reg_wr;
        w_wdata    = r_wdata;
        w_rd_lo    = r_rd_lo;
        w_len      = r_len;
        w_ptr      = r_ptr;
        w_tmo      = r_tmo;
        w_abort    = 1'b0;
        w_next_op  = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start_exec) begin
                    w_state   = S_RD_LEN;
                    w_busy    = 1'b1;
                    w_err     = 1'b0;
                    w_out_len = '0;
                    w_in_addr = '0;
                    w_in_re   = 1'b1;
                    w_ph      = 1'b0;
                end
            end
            S_RD_LEN: begin
                if (!r_ph) begin
                    w_ph = 1'b1;
                end else if ((inram_q < 16'd2) || (32'(inram_q) > MAXI)) begin
                    w_abort = 1'b1;
                end else begin
                    w_len     = inram_q[AW-1:0];
                    w_in_addr = inram_q[AW-1:0];
                    w_in_re   = 1'b1;
                    w_ph      = 1'b0;
                    w_state   = S_CHK_MAGIC;
                end
            end
            S_CHK_MAGIC: begin
                if (!r_ph) begin
                    w_ph = 1'b1;
                end else if (inram_q != MAGIC) begin
                    w_abort = 1'b1;
                end else begin
                    // Marker word goes out alongside the first opcode fetch.
                    w_out_addr = '0;
                    w_out_d    = MAGIC;
                    w_out_we   = 1'b1;
                    w_ptr      = AW'(1);
                    w_in_addr  = AW'(1);
                    w_in_re    = 1'b1;
                    w_ph       = 1'b0;
                    w_state    = S_FETCH_OP;
                end
            end
            S_FETCH_OP: begin
                if (!r_ph) begin
                    w_ph = 1'b1;
                end else if (inram_q[15]) begin
                    // Both data words must lie strictly before the magic word.
                    if (32'(r_ptr) + 32'd2 >= 32'(r_len)) begin
                        w_abort = 1'b1;
                    end else begin
                        w_reg_addr = inram_q[13:0];
                        w_ptr      = r_ptr + 1'b1;
                        w_in_addr  = r_ptr + 1'b1;
                        w_in_re    = 1'b1;
                        w_ph       = 1'b0;
                        w_state    = S_FETCH_HI;
                    end
                end else begin
                    // A read appends two words; refuse it if they would not fit.
                    if (32'(r_out_len) + 32'd2 > MAXI) begin
                        w_abort = 1'b1;
                    end else begin
                        w_reg_addr = inram_q[13:0];
                        w_ptr      = r_ptr + 1'b1;
                        w_reg_rd   = 1'b1;
                        w_tmo      = '0;
                        w_state    = S_BUS;
                    end
                end
            end
            S_FETCH_HI: begin
                if (!r_ph) begin
                    w_ph = 1'b1;
                end else begin
                    w_wdata[31:16] = inram_q;
                    w_ptr          = r_ptr + 1'b1;
                    w_in_addr      = r_ptr + 1'b1;
                    w_in_re        = 1'b1;
                    w_ph           = 1'b0;
                    w_state        = S_FETCH_LO;
                end
            end
            S_FETCH_LO: begin
                if (!r_ph) begin
                    w_ph = 1'b1;
                end else begin
                    w_wdata[15:0] = inram_q;
                    w_ptr         = r_ptr + 1'b1;
                    w_reg_wr      = 1'b1;
                    w_tmo         = '0;
                    w_state       = S_BUS;
                end
            end
            S_BUS: begin
                if (reg_ready) begin
                    w_reg_rd = 1'b0;
                    w_reg_wr = 1'b0;
                    if (r_reg_rd) begin
                        w_out_addr = r_out_len + 1'b1;
                        w_out_d    = reg_readdata[31:16];
                        w_out_we   = 1'b1;
                        w_out_len  = r_out_len + 1'b1;
                        w_rd_lo    = reg_readdata[15:0];
                        w_state    = S_STORE_HI;
                    end else begin
                        w_next_op = 1'b1;
                    end
                end else if (r_tmo == TW'(TIMEOUT - 1)) begin
                    w_abort = 1'b1;
                end else begin
                    w_tmo = r_tmo + 1'b1;
                end
            end
            S_STORE_HI: begin
                w_out_addr = r_out_len + 1'b1;
                w_out_d    = r_rd_lo;
                w_out_we   = 1'b1;
                w_out_len  = r_out_len + 1'b1;
                w_state    = S_STORE_LO;
            end
            S_STORE_LO: begin
                w_next_op = 1'b1;
            end
            S_DONE: begin
                w_busy  = 1'b0;
                w_state = S_IDLE;
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase

        if (w_next_op) begin
            if (r_ptr == r_len) begin
                w_state = S_DONE;
            end else begin
                w_in_addr = r_ptr;
                w_in_re   = 1'b1;
                w_ph      = 1'b0;
                w_state   = S_FETCH_OP;
            end
        end

        if (w_abort) begin
            w_state  = S_DONE;
            w_err    = 1'b1;
            w_reg_rd = 1'b0;
            w_reg_wr = 1'b0;
        end
    end

    assign busy           = r_busy;
    assign err            = r_err;
    assign out_len        = r_out_len;
    assign inram_address  = r_in_addr;
    assign inram_re       = r_in_re;
    assign outram_address = r_out_addr;
    assign outram_we      = r_out_we;
    assign outram_d       = r_out_d;
    assign reg_addr       = r_reg_addr;
    assign reg_rd         = r_reg_rd;
    assign reg_wr         = r_reg_wr;
    assign reg_writedata  = r_wdata;

endmodule

// File: tb/tb_exec_cmd.sv
// ----------------------------------------------------------------------------
// tb_exec_cmd
//   Scoreboard bench for exec_cmd. A list-level reference model predicts the
//   register transactions, output RAM writes and final status of each run;
//   a monitor compares them as the DUT produces them.
// ----------------------------------------------------------------------------
module tb_exec_cmd;
    localparam int unsigned TAW   = 5;
    localparam int unsigned TTO   = 100;
    localparam int          MAXI  = (1 << TAW) - 1;
    localparam logic [15:0] MAGIC = 16'hCBAE;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           start_exec = 1'b0;
    logic           busy, err;
    logic [TAW-1:0] out_len, inram_address, outram_address;
    logic           inram_re, outram_we;
    logic [15:0]    inram_q, outram_d;
    logic [13:0]    reg_addr;
    logic           reg_rd, reg_wr, reg_ready;
    logic [31:0]    reg_writedata, reg_readdata;

    always #5 clk = ~clk;

    exec_cmd #(.AW(TAW), .TIMEOUT(TTO)) dut (
        .clk(clk), .rst(rst), .start_exec(start_exec), .busy(busy), .err(err),
        .out_len(out_len), .inram_address(inram_address), .inram_re(inram_re),
        .inram_q(inram_q), .outram_address(outram_address), .outram_we(outram_we),
        .outram_d(outram_d), .reg_addr(reg_addr), .reg_rd(reg_rd), .reg_wr(reg_wr),
        .reg_writedata(reg_writedata), .reg_ready(reg_ready), .reg_readdata(reg_readdata)
    );

    typedef struct { bit wr; logic [13:0] addr; logic [31:0] data; } bus_t;
    typedef struct { logic [TAW-1:0] addr; logic [15:0] d; } out_t;
    typedef struct { bit err; logic [TAW-1:0] len; } done_t;

    bus_t  exp_bus[$];
    out_t  exp_out[$];
    done_t exp_done[$];

    logic [15:0] inmem  [0:MAXI];
    logic [15:0] outmem [0:MAXI];
    logic [15:0] lst[$];
    logic [31:0] mregs[int];
    logic [31:0] dregs[int];

    int n_cmp = 0;
    int n_fail = 0;
    bit hang = 1'b0;
    int fixed_lat = -1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] seed_val(input int a);
        return ((32'(a) + 32'd1) * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    // RAMs: sample request at the edge, update data just after it.
    initial begin
        logic s_re, s_we;
        logic [TAW-1:0] s_ra, s_wa;
        logic [15:0] s_wd;
        inram_q = '0;
        forever begin
            @(posedge clk);
            s_re = inram_re; s_ra = inram_address;
            s_we = outram_we; s_wa = outram_address; s_wd = outram_d;
            #1;
            if (s_re) inram_q = inmem[s_ra];
            if (s_we) outmem[s_wa] = s_wd;
        end
    end

    // Register device with random (or fixed) response latency.
    initial begin
        bit in_req;
        int cnt;
        in_req = 0; cnt = 0;
        reg_ready = 1'b0;
        reg_readdata = '0;
        forever begin
            @(posedge clk); #1;
            reg_ready = 1'b0;
            if (!rst) begin
                in_req = 0;
            end else if (reg_rd || reg_wr) begin
                if (!in_req) begin
                    in_req = 1;
                    cnt = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
                end
                if (!hang) begin
                    if (cnt == 0) begin
                        reg_ready = 1'b1;
                        if (reg_wr) dregs[int'(reg_addr)] = reg_writedata;
                        else reg_readdata = dregs.exists(int'(reg_addr)) ?
                                            dregs[int'(reg_addr)] : seed_val(int'(reg_addr));
                        in_req = 0;
                    end else begin
                        cnt--;
                    end
                end
            end
        end
    end

    // Monitor: compare every DUT output event against the scoreboard queues.
    initial begin
        bit pb;
        bus_t b;
        out_t o;
        done_t d;
        pb = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                pb = 0;
            end else begin
                if (reg_ready && (reg_rd || reg_wr)) begin
                    chk("bus_expected", 64'(exp_bus.size() != 0), 1);
                    if (exp_bus.size() != 0) begin
                        b = exp_bus.pop_front();
                        chk("bus_not_both", 64'(reg_rd && reg_wr), 0);
                        chk("bus_kind", 64'(reg_wr), 64'(b.wr));
                        chk("bus_addr", 64'(reg_addr), 64'(b.addr));
                        chk("bus_data", b.wr ? 64'(reg_writedata) : 64'(reg_readdata), 64'(b.data));
                    end
                end
                if (outram_we) begin
                    chk("out_expected", 64'(exp_out.size() != 0), 1);
                    if (exp_out.size() != 0) begin
                        o = exp_out.pop_front();
                        chk("out_addr", 64'(outram_address), 64'(o.addr));
                        chk("out_data", 64'(outram_d), 64'(o.d));
                    end
                end
                if (pb && !busy) begin
                    chk("done_expected", 64'(exp_done.size() != 0), 1);
                    if (exp_done.size() != 0) begin
                        d = exp_done.pop_front();
                        chk("done_err", 64'(err), 64'(d.err));
                        chk("done_out_len", 64'(out_len), 64'(d.len));
                    end
                end
                pb = busy;
            end
        end
    end

    // List-level reference: interpret the list and register-file semantics.
    task automatic predict();
        int L, p, olen, a;
        bit e;
        logic [15:0] op;
        logic [31:0] v;
        bus_t b;
        out_t o;
        done_t d;
        L = int'(inmem[0]); e = 0; olen = 0;
        if (L < 2 || L > MAXI) e = 1;
        else if (inmem[L] != MAGIC) e = 1;
        else begin
            o.addr = '0; o.d = MAGIC; exp_out.push_back(o);
            p = 1;
            while (p != L && !e) begin
                op = inmem[p];
                a = int'(op[13:0]);
                if (op[15]) begin
                    if (p + 2 >= L || hang) e = 1;
                    else begin
                        b.wr = 1; b.addr = op[13:0]; b.data = {inmem[p+1], inmem[p+2]};
                        exp_bus.push_back(b);
                        mregs[a] = b.data;
                        p += 3;
                    end
                end else begin
                    if (olen + 2 > MAXI || hang) e = 1;
                    else begin
                        v = mregs.exists(a) ? mregs[a] : seed_val(a);
                        b.wr = 0; b.addr = op[13:0]; b.data = v;
                        exp_bus.push_back(b);
                        o.addr = TAW'(olen + 1); o.d = v[31:16]; exp_out.push_back(o);
                        o.addr = TAW'(olen + 2); o.d = v[15:0];  exp_out.push_back(o);
                        olen += 2;
                        p += 1;
                    end
                end
            end
        end
        d.err = e; d.len = TAW'(olen);
        exp_done.push_back(d);
    endtask

    task automatic load();
        for (int i = 0; i <= MAXI; i++) begin
            inmem[i]  = 16'($urandom);
            outmem[i] = '0;
        end
        for (int i = 0; i < lst.size(); i++) inmem[i] = lst[i];
    endtask

    task automatic gen_random(input int force_l);
        int L, p;
        for (int i = 0; i <= MAXI; i++) begin
            inmem[i]  = 16'($urandom);
            outmem[i] = '0;
        end
        if (force_l != 0) L = force_l;
        else if ($urandom_range(0, 19) == 0) L = int'($urandom_range(0, 1));
        else L = int'($urandom_range(2, MAXI));
        inmem[0] = 16'(L);
        p = 1;
        while (p < L) begin
            if ($urandom_range(0, 1) == 1) begin
                inmem[p] = {1'b1, 1'($urandom), 10'b0, 4'($urandom)};
                p += 3;
            end else begin
                inmem[p] = {1'b0, 1'($urandom), 10'b0, 4'($urandom)};
                p += 1;
            end
        end
        if (L >= 2) inmem[L] = ($urandom_range(0, 9) == 0) ? 16'h1111 : MAGIC;
    endtask

    task automatic run(input int inject_at, output int bcyc, output int rdc, output int wrc);
        int cyc;
        predict();
        @(posedge clk); #1 start_exec = 1'b1;
        @(posedge clk); #1 start_exec = 1'b0;
        chk("busy_rise", 64'(busy), 1);
        cyc = 0; bcyc = 1; rdc = 0; wrc = 0;
        while (busy && cyc < 3000) begin
            rdc += int'(reg_rd);
            wrc += int'(reg_wr);
            start_exec = (cyc == inject_at);
            @(posedge clk); #1;
            cyc++;
            if (busy) bcyc++;
        end
        start_exec = 1'b0;
        chk("run_finished", 64'(busy), 0);
        repeat (2) @(posedge clk);
        #1;
        chk("bus_queue_drained", 64'(exp_bus.size()), 0);
        chk("out_queue_drained", 64'(exp_out.size()), 0);
        chk("done_queue_drained", 64'(exp_done.size()), 0);
    endtask

    initial begin
        int bc, rc, wc;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy), 0);
        chk("rst_err", 64'(err), 0);
        chk("rst_out_len", 64'(out_len), 0);
        chk("rst_reg_rd", 64'(reg_rd), 0);
        chk("rst_reg_wr", 64'(reg_wr), 0);
        chk("rst_inram_re", 64'(inram_re), 0);
        chk("rst_outram_we", 64'(outram_we), 0);
        chk("rst_addrs", 64'({inram_address, outram_address, reg_addr}), 0);
        chk("rst_data", 64'({outram_d, reg_writedata}), 0);
        rst = 1'b1;
        repeat (2) @(posedge clk);

        // Single write.
        lst = '{16'd4, 16'h8010, 16'h1234, 16'h5678, MAGIC};
        load(); run(-1, bc, rc, wc);
        chk("wr_count", 64'(wc > 0), 1);

        // Single read, latency 3.
        dregs[5] = 32'hDEADBEEF; mregs[5] = 32'hDEADBEEF;
        fixed_lat = 3;
        lst = '{16'd2, 16'h0005, MAGIC};
        load(); run(-1, bc, rc, wc);
        fixed_lat = -1;
        chk("rd_outmem0", 64'(outmem[0]), 64'(MAGIC));
        chk("rd_outmem1", 64'(outmem[1]), 64'h0000DEAD);
        chk("rd_outmem2", 64'(outmem[2]), 64'h0000BEEF);

        // Bad magic: abort before any bus access.
        lst = '{16'd2, 16'h0005, 16'h1111};
        load(); run(-1, bc, rc, wc);
        chk("magic_busy_le6", 64'(bc <= 6), 1);
        chk("magic_no_bus", 64'(rc + wc), 0);

        // Truncated write.
        lst = '{16'd3, 16'h8001, 16'h0000, MAGIC};
        load(); run(-1, bc, rc, wc);
        chk("trunc_no_wr", 64'(wc), 0);

        // Length boundaries.
        lst = '{16'd0}; load(); run(-1, bc, rc, wc);
        lst = '{16'd1, MAGIC}; load(); run(-1, bc, rc, wc);
        lst = '{16'(MAXI + 1)}; load(); run(-1, bc, rc, wc);
        lst = '{16'hFFFF}; load(); run(-1, bc, rc, wc);

        // Output overflow: 16 reads into a 32-word output RAM.
        lst = '{16'd17};
        for (int i = 1; i <= 16; i++) lst.push_back(16'(i));
        lst.push_back(MAGIC);
        load(); run(-1, bc, rc, wc);

        // Randomized lists, first one at maximum length.
        for (int t = 0; t < 25; t++) begin
            gen_random(t == 0 ? MAXI : 0);
            run(-1, bc, rc, wc);
        end

        // Timeout with a second start while busy.
        hang = 1'b1;
        lst = '{16'd2, 16'h0009, MAGIC};
        load(); run(20, bc, rc, wc);
        hang = 1'b0;
        chk("timeout_rd_cycles", 64'(rc), 64'(TTO));
        repeat (10) @(posedge clk);
        #1;
        chk("second_start_ignored", 64'(busy), 0);

        // Asynchronous reset during a bus request.
        hang = 1'b1;
        lst = '{16'd2, 16'h0007, MAGIC};
        load(); predict();
        @(posedge clk); #1 start_exec = 1'b1;
        @(posedge clk); #1 start_exec = 1'b0;
        for (int i = 0; i < 50 && !reg_rd; i++) begin
            @(posedge clk); #1;
        end
        chk("reset_rd_seen", 64'(reg_rd), 1);
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("reset_busy_low", 64'(busy), 0);
        chk("reset_rd_low", 64'(reg_rd), 0);
        repeat (2) @(posedge clk);
        exp_bus.delete(); exp_out.delete(); exp_done.delete();
        hang = 1'b0;
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        lst = '{16'd5, 16'h8003, 16'hA5A5, 16'h5A5A, 16'h0003, MAGIC};
        load(); run(-1, bc, rc, wc);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end
endmodule
